// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: debounced button sequencing of an 8-bit LFSR (manual/free-run step, seed load, lockup recovery).
module lfsr_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         RATE_W          = 24,
  parameter logic [7:0] DEFAULT_SEED    = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_step,
  input  logic              btn_mode,
  input  logic              btn_load,
  input  logic [7:0]        sw_seed,
  input  logic [RATE_W-1:0] rate_div,
  input  logic [7:0]        lfsr_q,
  output logic              lfsr_step,
  output logic              lfsr_load,
  output logic [7:0]        lfsr_seed,
  output logic              mode_run,
  output logic [15:0]       step_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {MANUAL, RUN, LOAD, RECOVER} state_t;
  state_t            state_q, state_d, ret_q, ret_d;
  logic [2:0]        btn, ev;
  logic              step_q, step_d, hit;
  logic [7:0]        seed_q, seed_d, load_seed;
  logic [15:0]       count_q, count_d;
  logic [RATE_W-1:0] div_q, div_d;
  assign btn = {btn_load, btn_mode, btn_step};
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic          s1_q, s2_q, acc_q, acc_d, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
      acc_d = acc_q;
      cnt_d = '0;
      if (s2_q != acc_q) begin
        acc_d = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? ~acc_q : acc_q;
        cnt_d = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? '0 : cnt_q + 1'b1;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        acc_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= btn[b];
        s2_q   <= s1_q;
        acc_q  <= acc_d;
        prev_q <= acc_q;
        cnt_q  <= cnt_d;
      end
    end
    assign ev[b] = acc_q & ~prev_q;
  end
  assign hit        = div_q == rate_div;
  assign load_seed  = (sw_seed == 8'h00) ? DEFAULT_SEED : sw_seed;
  assign lfsr_step  = step_q;
  assign lfsr_load  = state_q == LOAD || state_q == RECOVER;
  assign lfsr_seed  = state_q == LOAD ? load_seed : state_q == RECOVER ? DEFAULT_SEED : seed_q;
  assign mode_run   = state_q == RUN || (lfsr_load && ret_q == RUN);
  assign step_count = count_q;
  // Recovery outranks every button; the divider only survives uninterrupted RUN cycles.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    step_d  = 1'b0;
    seed_d  = seed_q;
    count_d = count_q;
    div_d   = '0;
    case (state_q)
      MANUAL, RUN: begin
        if (lfsr_q == 8'h00) begin
          state_d = RECOVER;
          ret_d   = state_q;
          count_d = '0;
        end else if (ev[2]) begin
          state_d = LOAD;
          ret_d   = state_q;
          count_d = '0;
        end else if (ev[1]) state_d = (state_q == RUN) ? MANUAL : RUN;
        else if (state_q == RUN) begin
          step_d = hit;
          div_d  = hit ? '0 : div_q + 1'b1;
        end else step_d = ev[0];
      end
      default: begin
        state_d = ret_q;
        seed_d  = lfsr_seed;
      end
    endcase
    if (step_d) count_d = count_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      ret_q   <= MANUAL;
      step_q  <= 1'b0;
      seed_q  <= DEFAULT_SEED;
      count_q <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      step_q  <= step_d;
      seed_q  <= seed_d;
      count_q <= count_d;
      div_q   <= div_d;
    end
  end
endmodule

// File: doc/lfsr_ctrl.md
Name: lfsr_ctrl

Overview:
- Sequencing controller for the 8-bit display LFSR datapath; replaces the raw button-as-clock scheme with single-clock enable control.
- Debounces front-panel buttons and selects manual single-step or free-run stepping at a programmable rate.
- Handles seed loading and all-zero lockup recovery.
- Drives the LFSR's step enable, load strobe and seed bus; observes the LFSR state.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized cycles required before a button level is accepted (minimum 1).
- RATE_W, 24, width of the free-run divider input.
- DEFAULT_SEED, 8'h01, seed used on lockup recovery and when sw_seed is zero; must be nonzero.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- btn_step  input  1  raw step button, active-high, asynchronous to clk.
- btn_mode  input  1  raw mode-toggle button, active-high, asynchronous.
- btn_load  input  1  raw seed-load button, active-high, asynchronous.
- sw_seed  input  8  seed switches, sampled in LOAD.
- rate_div  input  RATE_W  free-run period minus one, in clk cycles.
- lfsr_q  input  8  current LFSR state.
- lfsr_step  output  1  one-cycle advance enable to the LFSR.
- lfsr_load  output  1  one-cycle parallel-load strobe.
- lfsr_seed  output  8  load value; valid while lfsr_load=1.
- mode_run  output  1  1 = free-run, 0 = manual.
- step_count  output  16  count of lfsr_step pulses since the last load.

Behaviour:
- Reset (async assert, sync release): state MANUAL; lfsr_step=0, lfsr_load=0, lfsr_seed=DEFAULT_SEED, mode_run=0, step_count=0; divider, debounce counters and sync flops cleared.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: resets whenever the synchronized level equals the accepted level; otherwise increments. The accepted level flips when the counter reaches DEBOUNCE_CYCLES.
  - Rising edge of the accepted level gives a one-cycle internal event.
- Latency: a clean 0→1 on btn_step in MANUAL asserts lfsr_step exactly DEBOUNCE_CYCLES+3 clk cycles after the first sampled-high edge. Glitches shorter than DEBOUNCE_CYCLES cycles produce no event. Button release produces no event.
- Event priority in one cycle: load > mode > step. Lower-priority events in that cycle are dropped, not queued.
- FSM states and transitions:
  - MANUAL: step event → lfsr_step=1 for one cycle. Mode event → RUN, divider cleared. Load event → LOAD, return target MANUAL.
  - RUN: divider counts 0..rate_div; lfsr_step=1 on the cycle the divider equals rate_div, then the divider wraps to 0. rate_div=0 gives a step every cycle. Step events are ignored. Mode event → MANUAL, divider cleared, no further steps. Load event → LOAD, return target RUN.
  - LOAD: exactly one cycle.
    - lfsr_load=1, lfsr_step=0.
    - lfsr_seed = sw_seed, or DEFAULT_SEED if sw_seed==0.
    - step_count cleared, divider cleared.
    - Next state is the return target; events arriving in this cycle are dropped.
  - RECOVER: entered from MANUAL or RUN when lfsr_q==8'h00 and no load is in progress, with priority over all button events that cycle.
    - One cycle: lfsr_load=1, lfsr_seed=DEFAULT_SEED, step_count cleared.
    - Returns to the state it came from.
- Load/step exclusivity: lfsr_step and lfsr_load are never both 1.
- Mode output: mode_run=1 in RUN, and in LOAD/RECOVER whose return target is RUN; 0 otherwise.
- step_count: increments on each lfsr_step pulse; wraps 16'hFFFF→0; cleared by LOAD/RECOVER.
- lfsr_seed holds its last loaded value between loads.
- rate_div changes take effect on the next divider comparison. If the divider exceeds the new rate_div, it continues to its natural wrap at 2^RATE_W−1→0 with no step at the wrap. This case is a documented corner.
- Reset mid-operation: all outputs return to reset values immediately on rst_n low, and any partially debounced press is discarded.

Test Plan:
- DEBOUNCE_CYCLES=4, MANUAL, lfsr_q=8'h01: hold btn_step high 20 cycles → exactly one lfsr_step pulse, 7 cycles after the first sampled-high edge; step_count=1.
- Pulse btn_step high for 3 cycles → no lfsr_step; a 10-cycle bounce train of 1–2 cycle pulses followed by a steady high → exactly one step.
- Press btn_mode with rate_div=4 → mode_run=1, lfsr_step every 5 cycles; after 10 steps step_count=10; press btn_mode again → mode_run=0, no further steps.
- sw_seed=8'hA5, press btn_load in RUN → one cycle lfsr_load=1, lfsr_seed=8'hA5, step_count=0; RUN resumes with the first step 5 cycles later. Repeat with sw_seed=0 → lfsr_seed=8'h01.
- Force lfsr_q=8'h00 in MANUAL → next cycle lfsr_load=1, lfsr_seed=DEFAULT_SEED; state stays MANUAL. Press load and mode in the same cycle → only LOAD occurs and mode_run is unchanged.
- Drive rst_n low during a RUN divider count and during a held debounced press → all outputs reset asynchronously. After release, no step occurs until a new press is debounced.
